// File: rtl/effective_address_unit.sv
// effective_address_unit: 65C02 effective-address generator.
// Takes latched operand bytes plus X/Y, performs indexing, zero-page wrap,
// zero-page pointer fetches and the page-cross fix-up cycle, then strobes
// ea_valid for one cycle with the final address.
//
// state  | meaning
// IDLE   | waiting for start, ready=1
// PTR_LO | reading pointer low byte from {00,p}
// PTR_HI | reading pointer high byte from {00,p+1}
// FIX    | page-cross fix-up, mem_addr shows the uncorrected address
// DONE   | ea/page_cross valid, ea_valid=1
module effective_address_unit (
    input  logic        fclk,
    input  logic        resb,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        force_fix,
    input  logic [7:0]  address_high_in,
    input  logic [7:0]  address_low_in,
    input  logic [7:0]  index_x,
    input  logic [7:0]  index_y,
    input  logic [7:0]  db_in,
    output logic        mem_read,
    output logic [15:0] mem_addr,
    output logic        ready,
    output logic [15:0] ea,
    output logic        ea_valid,
    output logic        page_cross
);

    typedef enum logic [2:0] {IDLE, PTR_LO, PTR_HI, FIX, DONE} state_t;

    localparam logic [3:0] M_ABS      = 4'd0;
    localparam logic [3:0] M_ABS_X    = 4'd1;
    localparam logic [3:0] M_ABS_Y    = 4'd2;
    localparam logic [3:0] M_ZP       = 4'd3;
    localparam logic [3:0] M_ZP_X     = 4'd4;
    localparam logic [3:0] M_ZP_Y     = 4'd5;
    localparam logic [3:0] M_ZP_IND   = 4'd6;
    localparam logic [3:0] M_ZP_IND_X = 4'd7;
    localparam logic [3:0] M_ZP_IND_Y = 4'd8;

    state_t      state, state_nx;
    logic [3:0]  mode_q;
    logic        force_q;
    logic [7:0]  idx_q;
    logic [7:0]  ptr_q;
    logic [7:0]  ptr_lo_q;
    logic [15:0] res_q;
    logic        res_pc_q;
    logic [15:0] fix_addr_q;
    logic [15:0] ea_q;
    logic        pc_q;

    logic [3:0]  mode_d;
    logic [7:0]  idx_sel;
    logic [15:0] add_base;
    logic [7:0]  add_idx;
    logic [15:0] sum;
    logic [8:0]  lo_sum;
    logic        carry;
    logic [15:0] res_c;
    logic        pc_c;

    // Shared adder: operands come from the inputs in IDLE and from the fetched pointer otherwise.
    always_comb begin
        mode_d   = (mode > M_ZP_IND_Y) ? M_ABS : mode;
        idx_sel  = (mode_d == M_ABS_Y || mode_d == M_ZP_Y || mode_d == M_ZP_IND_Y) ? index_y : index_x;
        add_base = (state == IDLE) ? {address_high_in, address_low_in} : {db_in, ptr_lo_q};
        add_idx  = (state == IDLE) ? idx_sel : idx_q;
        sum      = add_base + {8'h00, add_idx};
        lo_sum   = {1'b0, add_base[7:0]} + {1'b0, add_idx};
        carry    = lo_sum[8];
    end

    // Result and carry that will be committed when the request completes.
    always_comb begin
        res_c = 16'h0000;
        pc_c  = 1'b0;
        if (state == IDLE) begin
            case (mode_d)
                M_ABS_X, M_ABS_Y: begin
                    res_c = sum;
                    pc_c  = carry;
                end
                M_ZP:            res_c = {8'h00, address_low_in};
                M_ZP_X, M_ZP_Y:  res_c = {8'h00, sum[7:0]};
                default:         res_c = {address_high_in, address_low_in};
            endcase
        end else if (mode_q == M_ZP_IND_Y) begin
            res_c = sum;
            pc_c  = carry;
        end else begin
            res_c = {db_in, ptr_lo_q};
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mode_d)
                        M_ABS_X, M_ABS_Y:                  state_nx = (carry || force_fix) ? FIX : DONE;
                        M_ZP_IND, M_ZP_IND_X, M_ZP_IND_Y:  state_nx = PTR_LO;
                        default:                           state_nx = DONE;
                    endcase
                end
            end
            PTR_LO:  state_nx = PTR_HI;
            PTR_HI:  state_nx = (mode_q == M_ZP_IND_Y && (carry || force_q)) ? FIX : DONE;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) state <= IDLE;
        else       state <= state_nx;
    end

    // Request latch, pointer capture and result registers.
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            mode_q     <= M_ABS;
            force_q    <= 1'b0;
            idx_q      <= 8'h00;
            ptr_q      <= 8'h00;
            ptr_lo_q   <= 8'h00;
            res_q      <= 16'h0000;
            res_pc_q   <= 1'b0;
            fix_addr_q <= 16'h0000;
            ea_q       <= 16'h0000;
            pc_q       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mode_q  <= mode_d;
                force_q <= force_fix;
                idx_q   <= idx_sel;
                ptr_q   <= (mode_d == M_ZP_IND_X) ? sum[7:0] : address_low_in;
            end
            if (state == PTR_LO)
                ptr_lo_q <= db_in;
            if (state_nx == FIX) begin
                res_q      <= res_c;
                res_pc_q   <= pc_c;
                fix_addr_q <= {add_base[15:8], lo_sum[7:0]};
            end
            if (state_nx == DONE) begin
                ea_q <= (state == FIX) ? res_q : res_c;
                pc_q <= (state == FIX) ? res_pc_q : pc_c;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_read = 1'b0;
        mem_addr = 16'h0000;
        case (state)
            PTR_LO: begin
                mem_read = 1'b1;
                mem_addr = {8'h00, ptr_q};
            end
            PTR_HI: begin
                mem_read = 1'b1;
                mem_addr = {8'h00, ptr_q + 8'h01};
            end
            FIX:     mem_addr = fix_addr_q;
            default: ;
        endcase
    end

    assign ready      = (state == IDLE);
    assign ea_valid   = (state == DONE);
    assign ea         = ea_q;
    assign page_cross = pc_q;

endmodule
